// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle between the VGA timing generator, the pattern stage and the display side.
// The master drives timing and mode requests; the slave (pattern stage) returns colour and delayed syncs.
interface vga_pattern_gen_if;
  logic        h_pulse;
  logic        v_pulse;
  logic        video_valid;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        mode_next;
  logic [1:0]  mode;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  modport master (
    output h_pulse, v_pulse, video_valid, x_pos, y_pos, mode_next,
    input  mode, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b
  );

  modport slave (
    input  h_pulse, v_pulse, video_valid, x_pos, y_pos, mode_next,
    output mode, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Two-stage VGA test-pattern generator: bars, checker, gray ramp and a bouncing box.
// Define VGA_PATTERN_BORDER_EN to force a one-pixel white frame around the active area.
module vga_pattern_gen #(
  parameter int   HORI_ACTIVE = 1024,
  parameter int   VERT_ACTIVE = 768,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   BAR_WIDTH   = 128,
  parameter int   CHECK_SHIFT = 5,
  parameter int   RAMP_SHIFT  = 2,
  parameter int   BOX_SIZE    = 64,
  parameter int   BOX_STEP    = 4
) (
  input logic               clk,
  input logic               rst_n,
  vga_pattern_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAY  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [11:0] pos;
    logic        neg;
  } axis_t;

  // Advance one box axis by a step, reversing before it would leave [0, limit-BOX_SIZE].
  function automatic axis_t bounce(input axis_t cur, input int limit);
    axis_t       nxt;
    logic [12:0] p;
    p   = {1'b0, cur.pos};
    nxt = cur;
    if (!cur.neg && (p + 13'(BOX_SIZE + BOX_STEP) > 13'(limit))) begin
      nxt.neg = 1'b1;
      nxt.pos = cur.pos - 12'(BOX_STEP);
    end else if (cur.neg && (p < 13'(BOX_STEP))) begin
      nxt.neg = 1'b0;
      nxt.pos = cur.pos + 12'(BOX_STEP);
    end else if (cur.neg) begin
      nxt.pos = cur.pos - 12'(BOX_STEP);
    end else begin
      nxt.pos = cur.pos + 12'(BOX_STEP);
    end
    return nxt;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  mode_e       r_mode;
  logic        r_pending;
  logic [7:0]  r_frame_cnt;
  logic        r_vs_in_d;
  logic [11:0] r_box_x;
  logic [11:0] r_box_y;
  logic        r_dx_neg;
  logic        r_dy_neg;

  logic        r_hs1, r_vs1, r_de1;
  logic [2:0]  r_bar1;
  logic        r_chk1;
  logic [7:0]  r_gray1;
  logic        r_hit1;
  logic        r_hs2, r_vs2, r_de2;
  logic [23:0] r_rgb2;

  logic        w_frame_evt;
  logic [11:0] w_bar_div;
  logic [2:0]  w_bar_idx;
  logic        w_chk;
  logic [7:0]  w_gray;
  logic [12:0] w_x13, w_y13, w_bx13, w_by13;
  logic        w_hit;
  axis_t       w_ax_x, w_ax_y;
  logic [23:0] w_rgb;

  // Frame boundary is the first cycle the raw vertical sync reaches its active level.
  assign w_frame_evt = (bus.v_pulse == VS_POL) && (r_vs_in_d != VS_POL);

  assign w_bar_div = bus.x_pos / 12'(BAR_WIDTH);
  assign w_bar_idx = (w_bar_div > 12'd7) ? 3'd7 : w_bar_div[2:0];
  assign w_chk     = bus.x_pos[CHECK_SHIFT] ^ bus.y_pos[CHECK_SHIFT];
  assign w_gray    = bus.x_pos[RAMP_SHIFT+7:RAMP_SHIFT];

  assign w_x13  = {1'b0, bus.x_pos};
  assign w_y13  = {1'b0, bus.y_pos};
  assign w_bx13 = {1'b0, r_box_x};
  assign w_by13 = {1'b0, r_box_y};
  assign w_hit  = (w_x13 >= w_bx13) && (w_x13 < w_bx13 + 13'(BOX_SIZE)) &&
                  (w_y13 >= w_by13) && (w_y13 < w_by13 + 13'(BOX_SIZE));

  assign w_ax_x = bounce(axis_t'{pos: r_box_x, neg: r_dx_neg}, HORI_ACTIVE);
  assign w_ax_y = bounce(axis_t'{pos: r_box_y, neg: r_dy_neg}, VERT_ACTIVE);

  // NOTE: every sequential block uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= MODE_BARS;
      r_pending   <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_vs_in_d   <= ~VS_POL;
      r_box_x     <= 12'd0;
      r_box_y     <= 12'd0;
      r_dx_neg    <= 1'b0;
      r_dy_neg    <= 1'b0;
    end else begin
      r_vs_in_d <= bus.v_pulse;
      if (w_frame_evt) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_box_x     <= w_ax_x.pos;
        r_dx_neg    <= w_ax_x.neg;
        r_box_y     <= w_ax_y.pos;
        r_dy_neg    <= w_ax_y.neg;
        if (r_pending || bus.mode_next) begin
          r_mode    <= mode_e'(r_mode + 2'd1);
          r_pending <= 1'b0;
        end
      end else if (bus.mode_next) begin
        r_pending <= 1'b1;
      end
    end
  end

`ifdef VGA_PATTERN_BORDER_EN
  logic w_border;
  logic r_border1;

  assign w_border = (bus.x_pos == 12'd0) || (bus.x_pos == 12'(HORI_ACTIVE - 1)) ||
                    (bus.y_pos == 12'd0) || (bus.y_pos == 12'(VERT_ACTIVE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_border1 <= 1'b0;
    else        r_border1 <= w_border;
  end
`endif

  // Stage 1: register sync/DE and the per-pattern selects derived from the position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs1   <= ~HS_POL;
      r_vs1   <= ~VS_POL;
      r_de1   <= 1'b0;
      r_bar1  <= 3'd0;
      r_chk1  <= 1'b0;
      r_gray1 <= 8'd0;
      r_hit1  <= 1'b0;
    end else begin
      r_hs1   <= bus.h_pulse;
      r_vs1   <= bus.v_pulse;
      r_de1   <= bus.video_valid;
      r_bar1  <= w_bar_idx;
      r_chk1  <= w_chk;
      r_gray1 <= w_gray;
      r_hit1  <= w_hit;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches on every path.
  always_comb begin
    w_rgb = 24'h000000;
    if (r_de1) begin
      case (r_mode)
        MODE_BARS:  w_rgb = bar_colour(r_bar1);
        MODE_CHECK: w_rgb = r_chk1 ? 24'hFFFFFF : 24'h000000;
        MODE_GRAY:  w_rgb = {3{r_gray1}};
        MODE_BOX:   w_rgb = r_hit1 ? 24'hFF0000 : {16'h0000, r_frame_cnt};
        default:    w_rgb = 24'h000000;
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      if (r_border1) w_rgb = 24'hFFFFFF;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs2  <= ~HS_POL;
      r_vs2  <= ~VS_POL;
      r_de2  <= 1'b0;
      r_rgb2 <= 24'h000000;
    end else begin
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_de2  <= r_de1;
      r_rgb2 <= w_rgb;
    end
  end

  assign bus.mode   = r_mode;
  assign bus.vga_hs = r_hs2;
  assign bus.vga_vs = r_vs2;
  assign bus.vga_de = r_de2;
  assign bus.vga_r  = r_rgb2[23:16];
  assign bus.vga_g  = r_rgb2[15:8];
  assign bus.vga_b  = r_rgb2[7:0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: reset, every pattern, mode sequencing and box bounce.
// Expectations follow VGA_PATTERN_BORDER_EN when the bench is built with it.
module tb_vga_pattern_gen;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  vga_pattern_gen_if bus ();

  vga_pattern_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef VGA_PATTERN_BORDER_EN
  localparam logic [23:0] EXP_CORNER_BARS = 24'hFFFFFF;
  localparam logic [23:0] EXP_LEFT_GRAY   = 24'hFFFFFF;
`else
  localparam logic [23:0] EXP_CORNER_BARS = 24'h000000;
  localparam logic [23:0] EXP_LEFT_GRAY   = 24'h000000;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] rgb();
    return {bus.vga_r, bus.vga_g, bus.vga_b};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic de, input int x, input int y);
    bus.video_valid = de;
    bus.x_pos       = 12'(x);
    bus.y_pos       = 12'(y);
  endtask

  task automatic pulse_next();
    bus.mode_next = 1'b1;
    step(1);
    bus.mode_next = 1'b0;
    step(1);
  endtask

  task automatic frame(input logic nxt);
    bus.v_pulse   = 1'b0;
    bus.mode_next = nxt;
    step(1);
    bus.v_pulse   = 1'b1;
    bus.mode_next = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.h_pulse     = 1'b0;
    bus.v_pulse     = 1'b1;
    bus.mode_next   = 1'b0;
    drive(1'b1, 100, 100);
    step(3);
    total++; if (bus.vga_hs !== 1'b1) begin bad++; $display("FAIL reset_hs got=%b exp=1", bus.vga_hs); end
    total++; if (bus.vga_vs !== 1'b1) begin bad++; $display("FAIL reset_vs got=%b exp=1", bus.vga_vs); end
    total++; if (bus.vga_de !== 1'b0) begin bad++; $display("FAIL reset_de got=%b exp=0", bus.vga_de); end
    total++; if (rgb() !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=000000", rgb()); end
    total++; if (bus.mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", bus.mode); end
    bus.h_pulse = 1'b1;
    drive(1'b0, 100, 100);
    rst_n = 1'b1;
    step(3);
    drive(1'b1, 100, 100);
    step(1);
    total++; if (bus.vga_de !== 1'b0) begin bad++; $display("FAIL de_latency1 got=%b exp=0", bus.vga_de); end
    step(1);
    total++; if (bus.vga_de !== 1'b1) begin bad++; $display("FAIL de_latency2 got=%b exp=1", bus.vga_de); end
  endtask

  task automatic test_bars();
    int          xs  [6] = '{0, 127, 128, 256, 512, 1023};
    logic [23:0] exps[6];
    exps = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF, EXP_CORNER_BARS};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, xs[i], 100);
      step(2);
      total++;
      if (rgb() !== exps[i]) begin
        bad++; $display("FAIL bars x=%0d got=%h exp=%h", xs[i], rgb(), exps[i]);
      end
    end
    drive(1'b0, 128, 100);
    step(2);
    total++; if (rgb() !== 24'h0) begin bad++; $display("FAIL bars_blank got=%h exp=000000", rgb()); end
    total++; if (bus.vga_de !== 1'b0) begin bad++; $display("FAIL bars_blank_de got=%b exp=0", bus.vga_de); end
    bus.h_pulse = 1'b0;
    drive(1'b1, 128, 100);
    step(1);
    total++; if (bus.vga_hs !== 1'b1) begin bad++; $display("FAIL hs_align1 got=%b exp=1", bus.vga_hs); end
    step(1);
    total++; if (bus.vga_hs !== 1'b0) begin bad++; $display("FAIL hs_align2 got=%b exp=0", bus.vga_hs); end
    total++; if (rgb() !== 24'hFFFF00) begin bad++; $display("FAIL hs_align_rgb got=%h exp=FFFF00", rgb()); end
    bus.h_pulse = 1'b1;
    step(1);
  endtask

  task automatic test_mode_advance();
    pulse_next();
    pulse_next();
    pulse_next();
    total++; if (bus.mode !== 2'd0) begin bad++; $display("FAIL mode_hold got=%0d exp=0", bus.mode); end
    frame(1'b0);
    total++; if (bus.mode !== 2'd1) begin bad++; $display("FAIL mode_advance got=%0d exp=1", bus.mode); end
    frame(1'b0);
    total++; if (bus.mode !== 2'd1) begin bad++; $display("FAIL mode_single got=%0d exp=1", bus.mode); end
  endtask

  task automatic test_checker();
    int          xs  [4] = '{32, 32, 64, 64};
    int          ys  [4] = '{0, 32, 32, 64};
    logic [23:0] exps[4];
    exps = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, xs[i], ys[i]);
      step(2);
      total++;
      if (rgb() !== exps[i]) begin
        bad++; $display("FAIL checker x=%0d y=%0d got=%h exp=%h", xs[i], ys[i], rgb(), exps[i]);
      end
    end
  endtask

  task automatic test_gray_and_wrap();
    int          xs  [3] = '{4, 1020, 512};
    logic [23:0] exps[3];
    exps = '{24'h010101, 24'hFFFFFF, 24'h808080};
    frame(1'b1);
    total++; if (bus.mode !== 2'd2) begin bad++; $display("FAIL mode_same_cycle got=%0d exp=2", bus.mode); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, xs[i], 100);
      step(2);
      total++;
      if (rgb() !== exps[i]) begin
        bad++; $display("FAIL gray x=%0d got=%h exp=%h", xs[i], rgb(), exps[i]);
      end
    end
    pulse_next();
    frame(1'b0);
    total++; if (bus.mode !== 2'd3) begin bad++; $display("FAIL mode_to3 got=%0d exp=3", bus.mode); end
    pulse_next();
    frame(1'b0);
    total++; if (bus.mode !== 2'd0) begin bad++; $display("FAIL mode_wrap got=%0d exp=0", bus.mode); end
  endtask

  task automatic check_pix(input int x, input int y, input logic [23:0] exp, input int k);
    drive(1'b1, x, y);
    step(2);
    total++;
    if (rgb() !== exp) begin
      bad++; $display("FAIL box frame=%0d x=%0d y=%0d got=%h exp=%h", k, x, y, rgb(), exp);
    end
  endtask

  task automatic test_box();
    drive(1'b1, 300, 300);
    step(1);
    rst_n = 1'b0;
    #1;
    total++; if (bus.vga_de !== 1'b0) begin bad++; $display("FAIL midreset_de got=%b exp=0", bus.vga_de); end
    total++; if (rgb() !== 24'h0) begin bad++; $display("FAIL midreset_rgb got=%h exp=000000", rgb()); end
    step(1);
    rst_n = 1'b1;
    step(1);
    for (int k = 1; k <= 241; k++) begin
      frame(k <= 3);
      if (k == 3) begin
        total++; if (bus.mode !== 2'd3) begin bad++; $display("FAIL box_mode got=%0d exp=3", bus.mode); end
      end
      if (k == 176) begin
        check_pix(704, 704, 24'hFF0000, k);
        check_pix(704, 703, 24'h0000B0, k);
      end
      if (k == 177) begin
        check_pix(708, 700, 24'hFF0000, k);
        check_pix(708, 763, 24'hFF0000, k);
        check_pix(708, 764, 24'h0000B1, k);
      end
      if (k == 240) begin
        check_pix(960, 448, 24'hFF0000, k);
        check_pix(959, 448, 24'h0000F0, k);
      end
      if (k == 241) begin
        check_pix(956, 444, 24'hFF0000, k);
        check_pix(1020, 444, 24'h0000F1, k);
        check_pix(955, 444, 24'h0000F1, k);
      end
    end
  endtask

  task automatic test_border();
    frame(1'b1);
    total++; if (bus.mode !== 2'd0) begin bad++; $display("FAIL border_mode0 got=%0d exp=0", bus.mode); end
    drive(1'b1, 0, 100);
    step(2);
    total++; if (rgb() !== 24'hFFFFFF) begin bad++; $display("FAIL border_bars_left got=%h exp=FFFFFF", rgb()); end
    drive(1'b1, 1023, 767);
    step(2);
    total++; if (rgb() !== EXP_CORNER_BARS) begin bad++; $display("FAIL border_bars_corner got=%h exp=%h", rgb(), EXP_CORNER_BARS); end
    frame(1'b1);
    frame(1'b1);
    total++; if (bus.mode !== 2'd2) begin bad++; $display("FAIL border_mode2 got=%0d exp=2", bus.mode); end
    drive(1'b1, 0, 100);
    step(2);
    total++; if (rgb() !== EXP_LEFT_GRAY) begin bad++; $display("FAIL border_gray_left got=%h exp=%h", rgb(), EXP_LEFT_GRAY); end
    drive(1'b1, 1023, 767);
    step(2);
    total++; if (rgb() !== 24'hFFFFFF) begin bad++; $display("FAIL border_gray_corner got=%h exp=FFFFFF", rgb()); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_bars();
    test_mode_advance();
    test_checker();
    test_gray_and_wrap();
    test_box();
    test_border();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
